// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm -- multicycle MIPS main control unit
//
// Purpose
//   Sequences one instruction per FETCH..writeback pass. The opcode is decoded
//   in DECODE, and the state then drives the datapath mux selects, the enable
//   strobes and the ula_operation code. ula_control combines ula_operation
//   with the instruction's func field. Memory accesses in FETCH, MEM_READ and
//   MEM_WRITE stall until mem_ready is high.
//
// Ports
//   clock          in   1  rising-edge clock
//   reset_n        in   1  asynchronous active-low reset
//   opcode         in   6  IR[31:26]; stable from DECODE until the return to FETCH
//   zero           in   1  ULA zero flag, used in BRANCH
//   mem_ready      in   1  memory completes the current read/write this cycle
//   pc_write       out  1  PC load enable
//   pc_src         out  2  00 ULA result, 01 ULAOut (branch target), 10 jump target
//   i_or_d         out  1  0 address=PC, 1 address=ULAOut
//   mem_read       out  1  memory read request
//   mem_write      out  1  memory write request
//   ir_write       out  1  IR load enable
//   mem_to_reg     out  1  1 write-back data=MDR, 0 write-back data=ULAOut
//   reg_dst        out  1  1 rd, 0 rt
//   reg_write      out  1  register file write enable
//   ula_src_a      out  1  0 PC, 1 register A
//   ula_src_b      out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//   ula_operation  out  3  000 add, 001 sub, 010 R-type, 011 slti,
//                          100 andi, 101 ori, 110 xori
//   illegal_op     out  1  unknown opcode trapped
//   state          out  4  current state encoding, for debug
//
// Configuration
//   CONTROL_ILLEGAL_TRAP_EN
//     defined   : an unknown opcode in DECODE enters TRAP, which holds with
//                 illegal_op=1 until reset_n is asserted.
//     undefined : an unknown opcode returns to FETCH (2-cycle NOP); TRAP is
//                 unreachable and illegal_op is constant 0.
//
// Outputs are decoded from the state register (Moore). The FETCH/MEM strobes
// are additionally qualified by mem_ready and the BRANCH pc_write by zero, so
// those paths are combinational from the inputs. Because every strobe is a
// function of the state register, asserting reset_n drops them at once.
// ---------------------------------------------------------------------------
module control_fsm (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic [2:0] ula_operation,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_I_EXEC    = 4'd10,
    ST_I_WB      = 4'd11,
    ST_JUMP      = 4'd12,
    ST_TRAP      = 4'd13
  } state_t;

  // Opcodes of the supported ISA subset
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ula_operation codes
  localparam logic [2:0] ULA_ADD   = 3'b000;
  localparam logic [2:0] ULA_SUB   = 3'b001;
  localparam logic [2:0] ULA_RTYPE = 3'b010;
  localparam logic [2:0] ULA_SLTI  = 3'b011;
  localparam logic [2:0] ULA_ANDI  = 3'b100;
  localparam logic [2:0] ULA_ORI   = 3'b101;
  localparam logic [2:0] ULA_XORI  = 3'b110;

  // ula_src_b selects
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // pc_src selects
  localparam logic [1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  state_t state_r;
  state_t next_state_s;

  // Dispatch target out of DECODE for a given opcode.
  function automatic state_t decode_dispatch(input logic [5:0] op);
    state_t dst;
    case (op)
      OP_RTYPE:                                 dst = ST_R_EXEC;
      OP_LW, OP_SW:                             dst = ST_MEM_ADDR;
      OP_BEQ, OP_BNE:                           dst = ST_BRANCH;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: dst = ST_I_EXEC;
      OP_J:                                     dst = ST_JUMP;
`ifdef CONTROL_ILLEGAL_TRAP_EN
      default:                                  dst = ST_TRAP;
`else
      default:                                  dst = ST_FETCH;
`endif
    endcase
    return dst;
  endfunction

  // ULA operation for the immediate-form ALU instructions.
  function automatic logic [2:0] imm_ula_op(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_ADDI: code = ULA_ADD;
      OP_SLTI: code = ULA_SLTI;
      OP_ANDI: code = ULA_ANDI;
      OP_ORI:  code = ULA_ORI;
      OP_XORI: code = ULA_XORI;
      default: code = ULA_ADD;
    endcase
    return code;
  endfunction

  // State register; only reset_n clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        next_state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        next_state_s = decode_dispatch(opcode);
      end
      ST_MEM_ADDR: begin
        // opcode is still the lw/sw that brought us here; anything else
        // cannot occur but is steered back to FETCH rather than left hanging.
        if (opcode == OP_LW) begin
          next_state_s = ST_MEM_READ;
        end else if (opcode == OP_SW) begin
          next_state_s = ST_MEM_WRITE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_MEM_READ: begin
        if (mem_ready) begin
          next_state_s = ST_MEM_WB;
        end else begin
          next_state_s = ST_MEM_READ;
        end
      end
      ST_MEM_WB: begin
        next_state_s = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        if (mem_ready) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_MEM_WRITE;
        end
      end
      ST_R_EXEC: begin
        next_state_s = ST_R_WB;
      end
      ST_R_WB: begin
        next_state_s = ST_FETCH;
      end
      ST_BRANCH: begin
        next_state_s = ST_FETCH;
      end
      ST_I_EXEC: begin
        next_state_s = ST_I_WB;
      end
      ST_I_WB: begin
        next_state_s = ST_FETCH;
      end
      ST_JUMP: begin
        next_state_s = ST_FETCH;
      end
      ST_TRAP: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
        next_state_s = ST_TRAP;
`else
        next_state_s = ST_IDLE;
`endif
      end
      default: begin
        // Unused encodings recover through IDLE.
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: every strobe defaults to 0, then the current state sets its own.
  always_comb begin
    pc_write      = 1'b0;
    pc_src        = PC_SRC_ULA;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    ula_src_a     = 1'b0;
    ula_src_b     = SRC_B_REG;
    ula_operation = ULA_ADD;
    illegal_op    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        // PC + 4 computed while the instruction is read
        mem_read      = 1'b1;
        i_or_d        = 1'b0;
        ula_src_a     = 1'b0;
        ula_src_b     = SRC_B_FOUR;
        ula_operation = ULA_ADD;
        pc_src        = PC_SRC_ULA;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        // Branch target precomputed speculatively into ULAOut
        ula_src_a     = 1'b0;
        ula_src_b     = SRC_B_IMM_SH2;
        ula_operation = ULA_ADD;
      end
      ST_MEM_ADDR: begin
        ula_src_a     = 1'b1;
        ula_src_b     = SRC_B_IMM;
        ula_operation = ULA_ADD;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b0;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ula_src_a     = 1'b1;
        ula_src_b     = SRC_B_REG;
        ula_operation = ULA_RTYPE;
      end
      ST_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        ula_src_a     = 1'b1;
        ula_src_b     = SRC_B_REG;
        ula_operation = ULA_SUB;
        pc_src        = PC_SRC_TARGET;
        // Taken condition follows the live zero flag of the A-B subtraction
        if (opcode == OP_BNE) begin
          pc_write = ~zero;
        end else begin
          pc_write = zero;
        end
      end
      ST_I_EXEC: begin
        ula_src_a     = 1'b1;
        ula_src_b     = SRC_B_IMM;
        ula_operation = imm_ula_op(opcode);
      end
      ST_I_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
      end
      ST_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      ST_TRAP: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
`else
        illegal_op = 1'b0;
`endif
      end
      default: begin
        illegal_op = 1'b0;
      end
    endcase
  end

  assign state = state_r;

endmodule

// File: tb/tb_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_control_fsm -- self-checking bench for control_fsm
//
// An instruction-level reference model expands each instruction (opcode,
// zero flag, FETCH stall count, memory stall count) into its per-cycle
// sequence of expected states and strobes. A directed table plus a randomized
// instruction stream are expanded into one vector queue, which a loop applies
// and compares cycle by cycle. Hand-written sequences cover the trap hold and
// an asynchronous reset in the middle of a stalled store.
// Honours CONTROL_ILLEGAL_TRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_control_fsm;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, ula_src_a, illegal_op;
  logic [1:0] pc_src, ula_src_b;
  logic [2:0] ula_operation;
  logic [3:0] state;

  always #5 clock = ~clock;

  control_fsm dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .ula_src_a(ula_src_a), .ula_src_b(ula_src_b),
    .ula_operation(ula_operation), .illegal_op(illegal_op), .state(state)
  );

`ifdef CONTROL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, RT = 6'b000000, JMP = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic       ill;
  } outs_t;

  typedef struct {
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    outs_t      exp;
    string      tag;
  } vec_t;

  outs_t act;
  assign act = {state, pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, ula_src_a, ula_src_b,
                ula_operation, illegal_op};

  vec_t trace_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic outs_t in_state(input logic [3:0] s);
    outs_t o;
    o = '0;
    o.st = s;
    return o;
  endfunction

  // ULA code for an immediate ALU opcode; returns 0 when op is not one.
  function automatic bit imm_code(input logic [5:0] op, output logic [2:0] code);
    bit hit;
    hit = 1'b1;
    case (op)
      ADDI:    code = 3'b000;
      SLTI:    code = 3'b011;
      ANDI:    code = 3'b100;
      ORI:     code = 3'b101;
      XORI:    code = 3'b110;
      default: begin code = 3'b000; hit = 1'b0; end
    endcase
    return hit;
  endfunction

  task automatic push(input logic [5:0] op, input logic z, input logic rdy,
                      input outs_t e, input string tag);
    vec_t v;
    v.opcode = op; v.zero = z; v.mem_ready = rdy; v.exp = e; v.tag = tag;
    trace_q.push_back(v);
  endtask

  // Reference model: expand one instruction into its expected cycle sequence.
  task automatic add_instr(input logic [5:0] op, input logic z, input int fs, input int ms);
    outs_t      o;
    logic [2:0] code;
    string      t;
    t = $sformatf("op%02h", op);
    // FETCH: PC+4 with the read; IR/PC load only on the ready cycle
    for (int i = 0; i < fs; i++) begin
      o = in_state(4'd1); o.mr = 1'b1; o.sb = 2'b01;
      push(6'($urandom), 1'($urandom), 1'b0, o, {t, "/fetch_stall"});
    end
    o = in_state(4'd1); o.mr = 1'b1; o.sb = 2'b01; o.irw = 1'b1; o.pcw = 1'b1;
    push(6'($urandom), 1'($urandom), 1'b1, o, {t, "/fetch"});
    o = in_state(4'd2); o.sb = 2'b11;
    push(op, 1'($urandom), 1'($urandom), o, {t, "/decode"});
    if (op == RT) begin
      o = in_state(4'd7); o.sa = 1'b1; o.op = 3'b010;
      push(op, 1'($urandom), 1'($urandom), o, {t, "/r_exec"});
      o = in_state(4'd8); o.rw = 1'b1; o.rdst = 1'b1;
      push(op, 1'($urandom), 1'($urandom), o, {t, "/r_wb"});
    end else if (op == LW || op == SW) begin
      o = in_state(4'd3); o.sa = 1'b1; o.sb = 2'b10;
      push(op, 1'($urandom), 1'($urandom), o, {t, "/mem_addr"});
      o = in_state((op == LW) ? 4'd4 : 4'd6); o.iod = 1'b1;
      if (op == LW) o.mr = 1'b1; else o.mw = 1'b1;
      for (int i = 0; i < ms; i++) push(op, 1'($urandom), 1'b0, o, {t, "/mem_stall"});
      push(op, 1'($urandom), 1'b1, o, {t, "/mem_done"});
      if (op == LW) begin
        o = in_state(4'd5); o.rw = 1'b1; o.m2r = 1'b1;
        push(op, 1'($urandom), 1'($urandom), o, {t, "/mem_wb"});
      end
    end else if (op == BEQ || op == BNE) begin
      o = in_state(4'd9); o.sa = 1'b1; o.op = 3'b001; o.pcs = 2'b01;
      o.pcw = (op == BEQ) ? z : ~z;
      push(op, z, 1'($urandom), o, {t, "/branch"});
    end else if (imm_code(op, code)) begin
      o = in_state(4'd10); o.sa = 1'b1; o.sb = 2'b10; o.op = code;
      push(op, 1'($urandom), 1'($urandom), o, {t, "/i_exec"});
      o = in_state(4'd11); o.rw = 1'b1;
      push(op, 1'($urandom), 1'($urandom), o, {t, "/i_wb"});
    end else if (op == JMP) begin
      o = in_state(4'd12); o.pcs = 2'b10; o.pcw = 1'b1;
      push(op, 1'($urandom), 1'($urandom), o, {t, "/jump"});
    end else if (TRAP_EN) begin
      o = in_state(4'd13); o.ill = 1'b1;
      push(op, 1'($urandom), 1'($urandom), o, {t, "/trap"});
    end
  endtask

  task automatic check(input string tag, input outs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
               tag, act, exp, act.st, exp.st);
    end
  endtask

  // Apply each queued vector just after a falling edge and compare before the next rising edge.
  task automatic run_trace();
    foreach (trace_q[i]) begin
      opcode = trace_q[i].opcode;
      zero = trace_q[i].zero;
      mem_ready = trace_q[i].mem_ready;
      #1;
      check(trace_q[i].tag, trace_q[i].exp);
      tests++;
      if ((mem_read && mem_write) || (reg_write && pc_write)) begin
        fails++;
        $display("FAIL exclusive_strobes %s: mr=%b mw=%b rw=%b pcw=%b required no overlap",
                 trace_q[i].tag, mem_read, mem_write, reg_write, pc_write);
      end
      @(negedge clock);
    end
    trace_q.delete();
  endtask

  logic [5:0] legal_ops [11] = '{LW, SW, BEQ, BNE, RT, JMP, ADDI, SLTI, ANDI, ORI, XORI};
  logic [5:0] bad_ops   [3]  = '{6'b111111, 6'b010001, 6'b000001};

  initial begin
    outs_t o;
    int    n;
    repeat (3) @(negedge clock);
    #1 check("reset_all_zero", in_state(4'd0));
    @(negedge clock);
    reset_n = 1'b1;

    // Directed table
    push(6'($urandom), 1'($urandom), 1'($urandom), in_state(4'd0), "idle_after_reset");
    add_instr(LW, 1'b0, 0, 0);
    add_instr(SW, 1'b0, 0, 3);
    add_instr(BEQ, 1'b1, 0, 0);
    add_instr(BEQ, 1'b0, 0, 0);
    add_instr(BNE, 1'b0, 0, 0);
    add_instr(BNE, 1'b1, 0, 0);
    add_instr(RT, 1'b0, 0, 0);
    add_instr(XORI, 1'b0, 0, 0);
    add_instr(SLTI, 1'b0, 0, 0);
    add_instr(ADDI, 1'b0, 1, 0);
    add_instr(ANDI, 1'b0, 0, 0);
    add_instr(ORI, 1'b0, 0, 0);
    add_instr(JMP, 1'b0, 0, 0);
    add_instr(LW, 1'b0, 2, 2);
    if (!TRAP_EN) add_instr(6'b111111, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      if (!TRAP_EN && $urandom_range(0, 7) == 0)
        add_instr(bad_ops[$urandom_range(0, 2)], 1'($urandom), $urandom_range(0, 2), 0);
      else
        add_instr(legal_ops[$urandom_range(0, 10)], 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_trace();

    // Trap holds for 10 cycles, then only reset leaves it
    if (TRAP_EN) begin
      add_instr(6'b111111, 1'b0, 0, 0);
      o = in_state(4'd13); o.ill = 1'b1;
      for (int i = 0; i < 9; i++) push(6'($urandom), 1'($urandom), 1'($urandom), o, "trap_hold");
      run_trace();
      reset_n = 1'b0;
      #1 check("trap_reset", in_state(4'd0));
      @(negedge clock);
      reset_n = 1'b1;
      push(6'($urandom), 1'($urandom), 1'($urandom), in_state(4'd0), "idle_after_trap");
    end

    // Reset in the middle of a stalled store
    add_instr(SW, 1'b0, 0, 3);
    n = trace_q.size();
    trace_q.delete(n - 1);
    run_trace();
    opcode = SW;
    mem_ready = 1'b0;
    #2;
    o = in_state(4'd6); o.mw = 1'b1; o.iod = 1'b1;
    check("sw_stalled_before_reset", o);
    reset_n = 1'b0;
    #1 check("async_reset_mid_write", in_state(4'd0));
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check("idle_after_release", in_state(4'd0));
    @(posedge clock);
    #1;
    o = in_state(4'd1); o.mr = 1'b1; o.sb = 2'b01;
    check("fetch_after_release", o);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule
